// File: rtl/dio_cfg_arbiter.sv
// rtl/dio_cfg_arbiter.sv - round-robin arbiter for the shared DIO config write port
// Each accepted word yields a one-cycle cfg_en strobe followed by a programmable settle gap.
module dio_cfg_arbiter #(
  parameter int NREQ   = 4,
  parameter int CNT_W  = 8,
  parameter int WCNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     soft_clr,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*16-1:0]       req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic [CNT_W-1:0]         settle_cycles,
  output logic                     cfg_en,
  output logic [15:0]              cfg_data,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     busy,
  output logic [WCNT_W-1:0]        write_count
);

  localparam int IDW = $clog2(NREQ);
  localparam logic [IDW-1:0] LAST_INIT = IDW'(NREQ - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE} state_t;

  state_t              state_q, state_d;
  logic [IDW-1:0]      last_q, last_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                cfg_en_q, cfg_en_d;
  logic [15:0]         cfg_data_q, cfg_data_d;
  logic [IDW-1:0]      grant_id_q, grant_id_d;
  logic [WCNT_W-1:0]   wcount_q, wcount_d;

  logic [15:0]         req_word [NREQ];
  logic                gnt_found;
  logic [IDW-1:0]      gnt_idx;
  logic [IDW:0]        cand_sum;

  for (genvar i = 0; i < NREQ; i++) begin : g_word
    assign req_word[i] = req_data[16*i +: 16];
  end

  // Search starts one past the last winner and wraps modulo NREQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand_sum  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand_sum = {1'b0, last_q} + (IDW+1)'(k);
      if (cand_sum >= (IDW+1)'(NREQ)) begin
        cand_sum = cand_sum - (IDW+1)'(NREQ);
      end
      if (!gnt_found && req_valid[cand_sum[IDW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand_sum[IDW-1:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    cfg_en_d   = 1'b0;
    cfg_data_d = cfg_data_q;
    grant_id_d = grant_id_q;
    wcount_d   = wcount_q;
    req_ready  = '0;

    // A strobe already on the wire is always counted, even when aborted.
    if (state_q == ISSUE) begin
      wcount_d = wcount_q + 1'b1;
    end

    if (soft_clr) begin
      state_d = IDLE;
      last_d  = LAST_INIT;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_found) begin
            req_ready[gnt_idx] = 1'b1;
            cfg_en_d           = 1'b1;
            cfg_data_d         = req_word[gnt_idx];
            grant_id_d         = gnt_idx;
            last_d             = gnt_idx;
            cnt_d              = settle_cycles;
            state_d            = ISSUE;
          end
        end
        ISSUE: begin
          state_d = (cnt_q == '0) ? IDLE : SETTLE;
        end
        SETTLE: begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_q     <= LAST_INIT;
      cnt_q      <= '0;
      cfg_en_q   <= 1'b0;
      cfg_data_q <= 16'h0000;
      grant_id_q <= '0;
      wcount_q   <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      cfg_en_q   <= cfg_en_d;
      cfg_data_q <= cfg_data_d;
      grant_id_q <= grant_id_d;
      wcount_q   <= wcount_d;
    end
  end

  assign cfg_en      = cfg_en_q;
  assign cfg_data    = cfg_data_q;
  assign grant_id    = grant_id_q;
  assign write_count = wcount_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_dio_cfg_arbiter.sv
// tb/tb_dio_cfg_arbiter.sv - self-checking bench for dio_cfg_arbiter
// Reference model tracks accept/strobe/idle times rather than FSM states.
module tb_dio_cfg_arbiter;

  localparam int NREQ   = 4;
  localparam int CNT_W  = 8;
  localparam int WCNT_W = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                soft_clr;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*16-1:0]  req_data;
  logic [NREQ-1:0]     req_ready;
  logic [CNT_W-1:0]    settle_cycles;
  logic                cfg_en;
  logic [15:0]         cfg_data;
  logic [1:0]          grant_id;
  logic                busy;
  logic [WCNT_W-1:0]   write_count;

  dio_cfg_arbiter #(.NREQ(NREQ), .CNT_W(CNT_W), .WCNT_W(WCNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .soft_clr(soft_clr),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .settle_cycles(settle_cycles), .cfg_en(cfg_en), .cfg_data(cfg_data),
    .grant_id(grant_id), .busy(busy), .write_count(write_count)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int failed    = 0;

  // Model: time-based view of the arbiter.
  int                 cyc;
  int                 m_idle_at;
  int                 m_en_at;
  int                 m_last;
  logic [15:0]        m_data;
  logic [1:0]         m_gid;
  logic [WCNT_W-1:0]  m_count;
  logic [25:0]        exp_vec;
  logic [25:0]        obs_vec;

  assign obs_vec = {req_ready, cfg_en, busy, cfg_data, grant_id, write_count};

  function automatic void reset_model();
    cyc       = 0;
    m_idle_at = 0;
    m_en_at   = -1;
    m_last    = NREQ - 1;
    m_data    = 16'h0000;
    m_gid     = 2'd0;
    m_count   = '0;
  endfunction

  task automatic run_cycle(input logic [NREQ-1:0] v, input logic [NREQ*16-1:0] d,
                           input logic [CNT_W-1:0] s, input logic c);
    logic [NREQ-1:0] e_ready;
    logic            e_idle, e_en;
    int              g;
    @(posedge clk);
    #1;
    req_valid     = v;
    req_data      = d;
    settle_cycles = s;
    soft_clr      = c;
    e_idle  = (cyc >= m_idle_at);
    e_en    = (cyc == m_en_at);
    e_ready = '0;
    g       = -1;
    if (e_idle && !c) begin
      for (int k = 1; k <= NREQ; k++) begin
        if (g < 0 && v[(m_last + k) % NREQ]) g = (m_last + k) % NREQ;
      end
      if (g >= 0) e_ready[g] = 1'b1;
    end
    exp_vec = {e_ready, e_en, !e_idle, m_data, m_gid, m_count};
    if (e_en) m_count = m_count + 1'b1;
    if (c) begin
      m_last = NREQ - 1;
      if (m_idle_at > cyc + 1) m_idle_at = cyc + 1;
    end else if (g >= 0) begin
      m_data    = d[g*16 +: 16];
      m_gid     = 2'(g);
      m_last    = g;
      m_en_at   = cyc + 1;
      m_idle_at = cyc + 2 + int'(s);
    end
    cyc++;
    @(negedge clk);
  endtask

  // Abort whatever is running and park idle with the pointer at NREQ-1.
  task automatic settle_idle();
    for (int k = 0; k < 2; k++) begin
      run_cycle('0, '0, '0, k == 0);
      tests_run++;
      if (obs_vec !== exp_vec) begin
        failed++;
        $display("FAIL idle k=%0d got=%h want=%h", k, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; soft_clr = 1'b0; req_valid = '0; req_data = '0; settle_cycles = '0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (obs_vec !== 26'h0) begin
      failed++;
      $display("FAIL reset_values got=%h want=%h", obs_vec, 26'h0);
    end
    rst_n = 1'b1;
    reset_model();
  endtask

  task automatic test_single();
    logic [6:0] busy_pat = 7'b0011110;
    for (int k = 0; k < 7; k++) begin
      run_cycle(k == 0 ? 4'b0001 : 4'b0000, {48'h0, 16'h8000}, 8'd3, 1'b0);
      tests_run++;
      if (obs_vec !== exp_vec) begin
        failed++;
        $display("FAIL single_model k=%0d got=%h want=%h", k, obs_vec, exp_vec);
      end
      tests_run++;
      if (busy !== busy_pat[k]) begin
        failed++;
        $display("FAIL single_busy k=%0d got=%b want=%b", k, busy, busy_pat[k]);
      end
      if (k == 0) begin
        tests_run++;
        if (req_ready !== 4'b0001) begin
          failed++;
          $display("FAIL single_ready got=%b want=0001", req_ready);
        end
      end
      if (k == 1) begin
        tests_run++;
        if (cfg_en !== 1'b1 || cfg_data !== 16'h8000) begin
          failed++;
          $display("FAIL single_strobe got en=%b data=%h want en=1 data=8000", cfg_en, cfg_data);
        end
      end
      if (k == 5) begin
        tests_run++;
        if (write_count !== 2'd1) begin
          failed++;
          $display("FAIL single_count got=%0d want=1", write_count);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    logic [NREQ*16-1:0] d = {16'hC003, 16'hC002, 16'hC001, 16'hC000};
    logic [3:0]         exp_r;
    int                 gid;
    settle_idle();
    for (int k = 0; k < 16; k++) begin
      run_cycle(4'b1111, d, 8'd0, 1'b0);
      tests_run++;
      if (obs_vec !== exp_vec) begin
        failed++;
        $display("FAIL rr_model k=%0d got=%h want=%h", k, obs_vec, exp_vec);
      end
      if (k % 2 == 1) begin
        gid = ((k - 1) / 2) % 4;
        tests_run++;
        if (cfg_en !== 1'b1 || grant_id !== 2'(gid) || cfg_data !== 16'hC000 + 16'(gid)) begin
          failed++;
          $display("FAIL rr_grant k=%0d got en=%b id=%0d data=%h want id=%0d", k, cfg_en, grant_id, cfg_data, gid);
        end
      end else begin
        exp_r = 4'(1 << ((k / 2) % 4));
        tests_run++;
        if (cfg_en !== 1'b0 || req_ready !== exp_r) begin
          failed++;
          $display("FAIL rr_accept k=%0d got en=%b rdy=%b want en=0 rdy=%b", k, cfg_en, req_ready, exp_r);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    settle_idle();
    for (int k = 0; k < 6; k++) begin
      run_cycle(4'b0100, {16'h2222, 48'h0}, 8'd0, 1'b0);
      tests_run++;
      if (obs_vec !== exp_vec) begin
        failed++;
        $display("FAIL b2b_model k=%0d got=%h want=%h", k, obs_vec, exp_vec);
      end
      tests_run++;
      if (req_ready !== ((k % 2 == 0) ? 4'b0100 : 4'b0000) || cfg_en !== (k % 2 == 1)) begin
        failed++;
        $display("FAIL b2b_timing k=%0d got rdy=%b en=%b", k, req_ready, cfg_en);
      end
    end
  endtask

  task automatic test_soft_clr();
    logic [3:0] pend, want;
    for (int v = 0; v < 2; v++) begin
      settle_idle();
      pend = (v == 1) ? 4'b1001 : 4'b1000;
      want = (v == 1) ? 4'b0001 : 4'b1000;
      for (int k = 0; k < 5; k++) begin
        run_cycle(k == 0 ? 4'b0010 : pend, {16'h3333, 16'h0, 16'h1111, 16'h0A0A},
                  k == 0 ? 8'd10 : 8'd1, k == 3);
        tests_run++;
        if (obs_vec !== exp_vec) begin
          failed++;
          $display("FAIL clr_model v=%0d k=%0d got=%h want=%h", v, k, obs_vec, exp_vec);
        end
        if (k == 4) begin
          tests_run++;
          if (busy !== 1'b0 || req_ready !== want) begin
            failed++;
            $display("FAIL clr_regrant v=%0d got busy=%b rdy=%b want busy=0 rdy=%b", v, busy, req_ready, want);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid_issue();
    settle_idle();
    run_cycle(4'b0001, {48'h0, 16'h5A5A}, 8'd5, 1'b0);
    run_cycle(4'b0000, '0, 8'd5, 1'b0);
    tests_run++;
    if (cfg_en !== 1'b1) begin
      failed++;
      $display("FAIL rst_pre_strobe got=%b want=1", cfg_en);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (cfg_en !== 1'b0 || cfg_data !== 16'h0 || write_count !== '0 || busy !== 1'b0) begin
      failed++;
      $display("FAIL rst_async got en=%b data=%h cnt=%0d busy=%b want 0", cfg_en, cfg_data, write_count, busy);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    reset_model();
    for (int k = 0; k < 4; k++) begin
      run_cycle('0, '0, '0, 1'b0);
      tests_run++;
      if (obs_vec !== exp_vec || cfg_en !== 1'b0) begin
        failed++;
        $display("FAIL rst_after k=%0d got=%h want=%h", k, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_count_wrap();
    for (int k = 0; k < 9; k++) begin
      run_cycle(k < 8 ? 4'b0010 : 4'b0000, {32'h0, 16'h7777, 16'h0}, 8'd0, 1'b0);
      tests_run++;
      if (obs_vec !== exp_vec) begin
        failed++;
        $display("FAIL wrap_model k=%0d got=%h want=%h", k, obs_vec, exp_vec);
      end
    end
    tests_run++;
    if (write_count !== 2'd0) begin
      failed++;
      $display("FAIL wrap_count got=%0d want=0", write_count);
    end
  endtask

  task automatic test_random();
    logic [NREQ*16-1:0] d;
    for (int k = 0; k < 400; k++) begin
      d = {$urandom(), $urandom()};
      run_cycle(4'($urandom_range(0, 15)), d, 8'($urandom_range(0, 3)), $urandom_range(0, 15) == 0);
      tests_run++;
      if (obs_vec !== exp_vec) begin
        failed++;
        $display("FAIL random k=%0d got=%h want=%h", k, obs_vec, exp_vec);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_soft_clr();
    test_reset_mid_issue();
    test_count_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
